serial_addsub: RTL and testbench

Bit-serial signed two's-complement adder/subtractor with valid/ready handshakes on both sides. It computes A+B or A−B one bit per clock through a single full-adder slice, and flags carry-out and signed overflow. It is the sequential, area-minimal counterpart of the parallel 4-bit add/sub datapath. It answers operand requests from an upstream initiator, such as a bench stimulus driver or a control FSM, and returns one registered result per request.

---
 rtl/serial_addsub.sv | 101 ++++++++++
 tb/tb_serial_addsub.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/serial_addsub.sv
// Bit-serial signed add/subtract: one full-adder slice processes a bit per clock,
// producing a registered sum with carry-out and signed-overflow flags.
module serial_addsub #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovfl,
    output logic [1:0]       dbg_state
);
    localparam int CW = $clog2(WIDTH) + 1;

    // Handshakes: a transfer happens on a rising edge where valid && ready are both
    // high; the source holds its payload stable until then, and ready never depends
    // on valid in the same cycle (in_ready only in IDLE, out_valid only in DONE).
    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

    state_t            state, state_next;
    logic [WIDTH-1:0]  a_sr, b_sr;
    logic [WIDTH-2:0]  res_sr;
    logic              carry;
    logic [CW-1:0]     cnt;
    logic              accept, last;
    logic              bit_s, bit_c;
    logic [WIDTH-1:0]  res_full;

    assign accept   = in_valid && in_ready;
    assign last     = (cnt == CW'(WIDTH - 1));
    assign bit_s    = a_sr[0] ^ b_sr[0] ^ carry;
    assign bit_c    = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry) | (b_sr[0] & carry);
    assign res_full = {bit_s, res_sr};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept)    state_next = BUSY;
            BUSY:    if (last)      state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        dbg_state = state;
    end

    // Subtract is A + ~B + 1: the inversion happens at load and the +1 rides in as carry-in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum    <= '0;
            cout   <= 1'b0;
            ovfl   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_sr  <= a;
                        b_sr  <= sub ? ~b : b;
                        carry <= sub;
                        cnt   <= '0;
                    end
                end
                BUSY: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    res_sr <= res_full[WIDTH-1:1];
                    carry  <= bit_c;
                    cnt    <= cnt + CW'(1);
                    if (last) begin
                        // carry still holds the carry into the MSB on this cycle
                        sum  <= res_full;
                        cout <= bit_c;
                        ovfl <= carry ^ bit_c;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_addsub.sv
// Directed vector table, multi-cycle corner sequences and a random pass against
// an arithmetic golden model for serial_addsub (WIDTH = 4).
module tb_serial_addsub;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a, b;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout, ovfl;
    logic [1:0]   dbg_state;

    int checks = 0;
    int errors = 0;
    logic [W+1:0] exp_q[$];

    typedef struct {
        logic [W-1:0] va, vb;
        logic         vsub;
        logic [W-1:0] esum;
        logic         ecout, eovfl;
    } vec_t;

    vec_t vecs[6];

    serial_addsub #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovfl(ovfl), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
        int sx, sy, ux, uy, r;
        logic co, ov;
        sx = $signed(x);
        sy = $signed(y);
        ux = x;
        uy = y;
        r  = s ? sx - sy : sx + sy;
        ov = (r > 7) || (r < -8);
        co = s ? (ux >= uy) : ((ux + uy) > 15);
        return {ov, co, r[W-1:0]};
    endfunction

    // Called at #1 after a rising edge with the DUT in IDLE.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tsub,
                          input logic [W+1:0] e, input int hold, input bit poke, input string tag);
        int n;
        logic [W+1:0] exp_v;
        check({tag, " in_ready_idle"}, in_ready, 1);
        in_valid = 1'b1; a = ta; b = tb_; sub = tsub;
        @(posedge clk); #1;
        exp_q.push_back(e);
        in_valid = 1'b0;
        a = W'($urandom_range(0, 15)); b = W'($urandom_range(0, 15)); sub = ~tsub;
        n = 0;
        while (!out_valid && n < 20) begin
            in_valid = poke;
            @(posedge clk); #1;
            n++;
        end
        in_valid = 1'b0;
        check({tag, " latency"}, n, W);
        exp_v = exp_q.pop_front();
        check({tag, " sum"},  sum,  exp_v[W-1:0]);
        check({tag, " cout"}, cout, exp_v[W]);
        check({tag, " ovfl"}, ovfl, exp_v[W+1]);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check({tag, " hold_valid"}, out_valid, 1);
            check({tag, " hold_ready"}, in_ready, 0);
            check({tag, " hold_res"}, {ovfl, cout, sum}, exp_v);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, " consumed"}, out_valid, 0);
        check({tag, " back_idle"}, {in_ready, dbg_state}, {1'b1, 2'd0});
        check({tag, " keep_res"}, {ovfl, cout, sum}, exp_v);
    endtask

    initial begin
        int seen;
        logic [W-1:0] ra, rb;
        logic rs;

        vecs[0] = '{4'd3,  4'd2, 1'b0, 4'b0101, 1'b0, 1'b0};
        vecs[1] = '{4'd7,  4'd1, 1'b0, 4'b1000, 1'b0, 1'b1};
        vecs[2] = '{4'h8,  4'd1, 1'b1, 4'b0111, 1'b1, 1'b1};
        vecs[3] = '{4'd3,  4'd5, 1'b1, 4'b1110, 1'b0, 1'b0};
        vecs[4] = '{4'hF,  4'hF, 1'b0, 4'b1110, 1'b1, 1'b0};
        vecs[5] = '{4'd0,  4'd0, 1'b1, 4'b0000, 1'b1, 1'b0};

        // clock / reset
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; sub = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", {in_ready, out_valid, sum, cout, ovfl}, {1'b1, 1'b0, 4'd0, 1'b0, 1'b0});
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // table-driven directed vectors
        foreach (vecs[i])
            run_op(vecs[i].va, vecs[i].vb, vecs[i].vsub,
                   {vecs[i].eovfl, vecs[i].ecout, vecs[i].esum}, 0, 1'b0, $sformatf("vec%0d", i));

        // stall in DONE with in_valid pulsed during BUSY
        run_op(4'd3, 4'd5, 1'b1, {1'b0, 1'b0, 4'b1110}, 5, 1'b1, "stall");
        repeat (W + 2) @(posedge clk);
        #1;
        check("no_ghost_result", out_valid, 0);

        // reset in the second BUSY cycle
        in_valid = 1'b1; a = 4'd7; b = 4'd1; sub = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check("abort_busy", {in_ready, out_valid, sum, cout, ovfl}, {1'b1, 1'b0, 4'd0, 1'b0, 1'b0});
        @(negedge clk) rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < W + 3; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        check("abort_no_valid", seen, 0);

        // asynchronous reset while a result is held in DONE
        in_valid = 1'b1; a = 4'd7; b = 4'd1; sub = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (W) @(posedge clk);
        #1;
        check("done_before_reset", {out_valid, ovfl, cout, sum}, {1'b1, 1'b1, 1'b0, 4'b1000});
        #3 rst_n = 1'b0;
        #1;
        check("abort_done", {in_ready, out_valid, sum, cout, ovfl}, {1'b1, 1'b0, 4'd0, 1'b0, 1'b0});
        exp_q.delete();
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // random triples against the golden model
        for (int i = 0; i < 100; i++) begin
            ra = W'($urandom_range(0, 15));
            rb = W'($urandom_range(0, 15));
            rs = 1'($urandom_range(0, 1));
            run_op(ra, rb, rs, model(ra, rb, rs), 0, 1'b0, $sformatf("rnd%0d", i));
        end

        check("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
